// File: rtl/byte_transmitter_mux_if.sv
// Interface bundling the serialiser control inputs, parallel word, TAP mux select and outputs.
// master drives the controls (TAP side); slave is the transmitter/mux.
interface byte_transmitter_mux_if #(
    parameter int unsigned WIDTH = 32
);
    logic             clear;
    logic             enable;
    logic [WIDTH-1:0] in;
    logic             tap_in;
    logic             sel;
    logic             tx_bit;
    logic             done;
    logic             out;

    modport master (
        output clear, enable, in, tap_in, sel,
        input  tx_bit, done, out
    );

    modport slave (
        input  clear, enable, in, tap_in, sel,
        output tx_bit, done, out
    );
endinterface

// File: rtl/byte_transmitter_mux.sv
// Parallel-to-serial transmitter (LSB first by default, MSB first with BYTE_TX_MSB_FIRST_EN)
// plus the combinational TAP/serial output select feeding TDO.
module byte_transmitter_mux #(
    parameter int unsigned WIDTH = 32
) (
    input logic                  clk,
    input logic                  reset_n,
    byte_transmitter_mux_if.slave bus
);
    localparam int unsigned    CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shadow_q;
    logic [CW-1:0]    count_q;
    logic             tx_bit_q;
    logic             done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            count_q  <= '0;
            tx_bit_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.clear) begin
            // Shadow is left alone; the next start re-captures the word anyway.
            state_q  <= StIdle;
            count_q  <= '0;
            tx_bit_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.enable) begin
            unique case (state_q)
                StIdle: begin
`ifdef BYTE_TX_MSB_FIRST_EN
                    tx_bit_q <= bus.in[WIDTH-1];
                    shadow_q <= bus.in << 1;
`else
                    tx_bit_q <= bus.in[0];
                    shadow_q <= bus.in >> 1;
`endif
                    count_q  <= CW'(1);
                    state_q  <= StShift;
                end
                StShift: begin
`ifdef BYTE_TX_MSB_FIRST_EN
                    tx_bit_q <= shadow_q[WIDTH-1];
                    shadow_q <= shadow_q << 1;
`else
                    tx_bit_q <= shadow_q[0];
                    shadow_q <= shadow_q >> 1;
`endif
                    count_q  <= count_q + CW'(1);
                    // Last bit and done rise on the same edge.
                    if (count_q == LAST) begin
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    tx_bit_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.tx_bit = tx_bit_q;
    assign bus.done   = done_q;
    assign bus.out    = bus.sel ? bus.tap_in : tx_bit_q;

endmodule

// File: tb/tb_byte_transmitter_mux.sv
// Self-checking bench for byte_transmitter_mux: table-driven word stream plus pause,
// async reset and mux corner sequences. Honours BYTE_TX_MSB_FIRST_EN for bit order.
module tb_byte_transmitter_mux;
    localparam int unsigned WIDTH = 32;
    localparam logic [31:0] WORD  = 32'h000FAF01;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    byte_transmitter_mux_if #(.WIDTH(WIDTH)) bus ();

    byte_transmitter_mux #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clear;
        logic        enable;
        logic [31:0] in;
        logic        sel;
        logic        tap_in;
        logic        exp_tx;
        logic        exp_done;
        logic        exp_out;
    } vec_t;

    vec_t vecs[40];

    // Bit k of the stream for word w in the configured order.
    function automatic logic stream_bit(input logic [31:0] w, input int k);
`ifdef BYTE_TX_MSB_FIRST_EN
        return w[31-k];
`else
        return w[k];
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic e, input logic [31:0] w,
                         input logic s, input logic t);
        bus.clear  = c;
        bus.enable = e;
        bus.in     = w;
        bus.sel    = s;
        bus.tap_in = t;
    endtask

    initial begin
        logic [31:0] got_word;
        logic [15:0] first16;
        logic [15:0] exp16;
        int          n;

        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, WORD, 1'b0, 1'b0);

        // Full word, input changed after capture, sticky done, clear-over-enable, restart.
        for (int i = 0; i < 32; i++) begin
            vecs[i].clear    = 1'b0;
            vecs[i].enable   = 1'b1;
            vecs[i].in       = (i == 0) ? WORD : 32'hFFFFFFFF;
            vecs[i].sel      = (i % 5 == 3);
            vecs[i].tap_in   = (i % 2 == 0);
            vecs[i].exp_tx   = stream_bit(WORD, i);
            vecs[i].exp_done = (i == 31);
        end
        for (int i = 32; i < 35; i++) begin
            vecs[i].clear    = 1'b0;
            vecs[i].enable   = 1'b1;
            vecs[i].in       = WORD;
            vecs[i].sel      = (i == 33);
            vecs[i].tap_in   = 1'b1;
            vecs[i].exp_tx   = 1'b0;
            vecs[i].exp_done = 1'b1;
        end
        vecs[35] = '{1'b1, 1'b1, WORD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[36] = '{1'b0, 1'b0, WORD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[37] = '{1'b0, 1'b1, WORD, 1'b0, 1'b0, stream_bit(WORD, 0), 1'b0, 1'b0};
        vecs[38] = '{1'b0, 1'b1, WORD, 1'b0, 1'b0, stream_bit(WORD, 1), 1'b0, 1'b0};
        vecs[39] = '{1'b0, 1'b0, WORD, 1'b1, 1'b0, stream_bit(WORD, 1), 1'b0, 1'b0};
        for (int i = 0; i < 40; i++)
            vecs[i].exp_out = vecs[i].sel ? vecs[i].tap_in : vecs[i].exp_tx;

        // Reset state, including the mux which must stay live in reset.
        #12;
        check("reset_tx_bit", {31'b0, bus.tx_bit}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_out_serial", {31'b0, bus.out}, 32'd0);
        bus.sel = 1'b1; bus.tap_in = 1'b1; #1;
        check("reset_out_tap", {31'b0, bus.out}, 32'd1);
        bus.sel = 1'b0; bus.tap_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        got_word = '0;
        for (int i = 0; i < 40; i++) begin
            drive(vecs[i].clear, vecs[i].enable, vecs[i].in, vecs[i].sel, vecs[i].tap_in);
            step();
            check($sformatf("vec%0d_tx_bit", i), {31'b0, bus.tx_bit}, {31'b0, vecs[i].exp_tx});
            check($sformatf("vec%0d_done", i), {31'b0, bus.done}, {31'b0, vecs[i].exp_done});
            check($sformatf("vec%0d_out", i), {31'b0, bus.out}, {31'b0, vecs[i].exp_out});
            if (i < 32) got_word[i] = bus.tx_bit;
            if (i == 15) first16 = got_word[15:0];
        end
`ifdef BYTE_TX_MSB_FIRST_EN
        exp16 = 16'b1111_0000_0000_0000;
        check("word_stream_msb", got_word,
              {<<{WORD}});
`else
        exp16 = 16'b1010_1111_0000_0001;
        check("word_stream_lsb", got_word, WORD);
`endif
        check("first16_literal", {16'b0, first16}, {16'b0, exp16});

        // Pause after bit 7 for three cycles, then resume to completion.
        drive(1'b1, 1'b0, WORD, 1'b0, 1'b0);
        step();
        got_word = '0;
        bus.clear = 1'b0; bus.enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            got_word[i] = bus.tx_bit;
        end
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("pause_tx_hold", {31'b0, bus.tx_bit}, {31'b0, stream_bit(WORD, 7)});
            check("pause_done_low", {31'b0, bus.done}, 32'd0);
        end
        bus.enable = 1'b1;
        n = 8;
        while (!bus.done && n < 40) begin
            step();
            if (n < 32) got_word[n] = bus.tx_bit;
            if (n == 8) check("resume_bit8", {31'b0, bus.tx_bit}, {31'b0, stream_bit(WORD, 8)});
            n++;
        end
        check("pause_bit_count", n, 32);
`ifdef BYTE_TX_MSB_FIRST_EN
        check("pause_word", got_word, {<<{WORD}});
`else
        check("pause_word", got_word, WORD);
`endif

        // Async reset mid-word at count 5 with tx_bit high.
        drive(1'b1, 1'b0, 32'h0800_0010, 1'b0, 1'b0);
        step();
        bus.clear = 1'b0; bus.enable = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("pre_reset_tx_bit", {31'b0, bus.tx_bit}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_tx_bit", {31'b0, bus.tx_bit}, 32'd0);
        check("async_reset_done", {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        bus.in = WORD;
        step();
        check("post_reset_bit0", {31'b0, bus.tx_bit}, {31'b0, stream_bit(WORD, 0)});
        step();
        check("post_reset_bit1", {31'b0, bus.tx_bit}, {31'b0, stream_bit(WORD, 1)});

        // Mux follows tap_in combinationally with no clock edge in between.
        bus.enable = 1'b0;
        bus.sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.tap_in = i[0];
            #1;
            check("mux_tap_follow", {31'b0, bus.out}, {31'b0, i[0]});
        end
        bus.sel = 1'b0;
        #1;
        check("mux_serial_follow", {31'b0, bus.out}, {31'b0, stream_bit(WORD, 1)});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
